// File: rtl/address_sequencer.sv
// Parametrised memory address sweeper with hold, wrap, pause and restart.
// All state updates on the falling clock edge so memory sees stable addresses.
module address_sequencer #(
   parameter int ADDR_WIDTH = 4,
   parameter int START_ADDR = 0,
   parameter int END_ADDR   = 2**ADDR_WIDTH-1,
   parameter int STEP       = 1,
   parameter int HOLD_FIRST = 1,
   parameter int WRAP_MODE  = 0
) (
   input  logic                  clockSequencer,
   input  logic                  resetSequencer,
   input  logic                  enableSequencer,
   input  logic                  restartSequencer,
   output logic [ADDR_WIDTH-1:0] addressSequencer,
   output logic                  validSequencer,
   output logic                  finishedSequencer,
   output logic                  wrapSequencer
);

   typedef enum logic [1:0] {
      FIRST = 2'd0,
      RUN   = 2'd1,
      DONE  = 2'd2
   } seqState_t;

   if (ADDR_WIDTH < 1 ||
       START_ADDR > END_ADDR ||
       STEP == 0 ||
       STEP >= 2**ADDR_WIDTH ||
       END_ADDR >= 2**ADDR_WIDTH) begin : gBadParams
      $error("address_sequencer: illegal parameter set");
   end

   localparam seqState_t resetState =
      (HOLD_FIRST != 0) ? FIRST : RUN;
   localparam logic [ADDR_WIDTH-1:0] startVal =
      ADDR_WIDTH'(START_ADDR);
   localparam logic [ADDR_WIDTH:0] stepExt =
      (ADDR_WIDTH+1)'(STEP);
   localparam logic [ADDR_WIDTH:0] endExt =
      (ADDR_WIDTH+1)'(END_ADDR);
   localparam logic wrapOn = (WRAP_MODE != 0);

   seqState_t             state;
   seqState_t             stateNxt;
   logic [ADDR_WIDTH-1:0] address;
   logic [ADDR_WIDTH-1:0] addressNxt;
   logic                  valid;
   logic                  validNxt;
   logic                  finished;
   logic                  finishedNxt;
   logic                  wrap;
   logic                  wrapNxt;
   logic [ADDR_WIDTH:0]   nxtSum;
   logic                  overEnd;

   // Carry bit kept so a step past 2**ADDR_WIDTH cannot alias low
   always_comb begin
      nxtSum  = {1'b0, address} + stepExt;
      overEnd = (nxtSum > endExt);
   end

   // Next-state and next-output selection; restart outranks enable
   always_comb begin
      stateNxt    = state;
      addressNxt  = address;
      validNxt    = valid;
      finishedNxt = finished;
      wrapNxt     = 1'b0;
      priority case (1'b1)
         restartSequencer: begin
            stateNxt    = resetState;
            addressNxt  = startVal;
            validNxt    = 1'b1;
            finishedNxt = 1'b0;
         end
         !enableSequencer: begin
         end
         (state == FIRST): begin
            stateNxt = RUN;
         end
         (state == RUN && !overEnd): begin
            addressNxt = nxtSum[ADDR_WIDTH-1:0];
         end
         (state == RUN && wrapOn): begin
            addressNxt = startVal;
            wrapNxt    = 1'b1;
         end
         (state == RUN): begin
            stateNxt    = DONE;
            validNxt    = 1'b0;
            finishedNxt = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // State and output registers, falling edge, async reset
   always_ff @(negedge clockSequencer or posedge resetSequencer) begin
      if (resetSequencer) begin
         state    <= resetState;
         address  <= startVal;
         valid    <= 1'b1;
         finished <= 1'b0;
         wrap     <= 1'b0;
      end else begin
         state    <= stateNxt;
         address  <= addressNxt;
         valid    <= validNxt;
         finished <= finishedNxt;
         wrap     <= wrapNxt;
      end
   end

   assign addressSequencer  = address;
   assign validSequencer    = valid;
   assign finishedSequencer = finished;
   assign wrapSequencer     = wrap;

endmodule

// File: tb/tb_address_sequencer.sv
// Directed bench for address_sequencer across four parameter sets.
// Outputs sampled just after posedge, away from the active negedge.
module tb_address_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rstA, rstB;
   logic en0, en1, en2, en3;
   logic rs0, rsOff;

   logic [3:0] a0, a1, a2;
   logic [7:0] a3;
   logic v0, f0, w0;
   logic v1, f1, w1;
   logic v2, f2, w2;
   logic v3, f3, w3;

   int nCompared   = 0;
   int nMismatched = 0;

   address_sequencer u0 (
      .clockSequencer(clk), .resetSequencer(rstA),
      .enableSequencer(en0), .restartSequencer(rs0),
      .addressSequencer(a0), .validSequencer(v0),
      .finishedSequencer(f0), .wrapSequencer(w0));

   address_sequencer #(
      .STEP(3), .END_ADDR(10), .HOLD_FIRST(0)
   ) u1 (
      .clockSequencer(clk), .resetSequencer(rstB),
      .enableSequencer(en1), .restartSequencer(rsOff),
      .addressSequencer(a1), .validSequencer(v1),
      .finishedSequencer(f1), .wrapSequencer(w1));

   address_sequencer #(
      .WRAP_MODE(1), .START_ADDR(2), .END_ADDR(5)
   ) u2 (
      .clockSequencer(clk), .resetSequencer(rstB),
      .enableSequencer(en2), .restartSequencer(rsOff),
      .addressSequencer(a2), .validSequencer(v2),
      .finishedSequencer(f2), .wrapSequencer(w2));

   address_sequencer #(
      .ADDR_WIDTH(8), .END_ADDR(255)
   ) u3 (
      .clockSequencer(clk), .resetSequencer(rstB),
      .enableSequencer(en3), .restartSequencer(rsOff),
      .addressSequencer(a3), .validSequencer(v3),
      .finishedSequencer(f3), .wrapSequencer(w3));

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      nCompared++;
      if (obs !== exp) begin
         nMismatched++;
         $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   task automatic chk0(input string tag, input int addr,
                       input logic v, input logic f);
      check({tag, ".addr"}, 32'(a0), 32'(addr));
      check({tag, ".valid"}, 32'(v0), 32'(v));
      check({tag, ".fin"}, 32'(f0), 32'(f));
   endtask

   int exp2A[6] = '{2, 3, 4, 5, 2, 3};
   int exp2W[6] = '{0, 0, 0, 0, 1, 0};
   int exp1A[3] = '{3, 6, 9};

   initial begin
      rstA = 0; rstB = 0; rs0 = 0; rsOff = 0;
      en0 = 0; en1 = 0; en2 = 0; en3 = 0;
      #1;
      rstA = 1; rstB = 1;
      #1;
      chk0("rst", 0, 1'b1, 1'b0);
      check("rst.wrap", 32'(w0), 0);
      check("rst.u1addr", 32'(a1), 0);
      check("rst.u2addr", 32'(a2), 2);
      check("rst.u3addr", 32'(a3), 0);
      @(posedge clk); #1;
      rstA = 0; rstB = 0;

      // T1: full default sweep
      en0 = 1;
      for (int k = 1; k <= 16; k++) begin
         tick();
         check("t1.addr", 32'(a0), 32'((k == 1) ? 0 : k - 1));
         check("t1.valid", 32'(v0), 1);
      end
      tick();
      chk0("t1.done", 15, 1'b0, 1'b1);
      tick();
      chk0("t1.absorb", 15, 1'b0, 1'b1);

      // T5: restart from DONE
      rs0 = 1;
      tick();
      rs0 = 0;
      chk0("t5.rsDone", 0, 1'b1, 1'b0);
      tick();
      chk0("t5.hold", 0, 1'b1, 1'b0);
      for (int k = 1; k <= 7; k++) tick();
      chk0("t4.at7", 7, 1'b1, 1'b0);

      // T4: pause at 7
      en0 = 0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk0("t4.pause", 7, 1'b1, 1'b0);
         check("t4.wrap", 32'(w0), 0);
      end
      en0 = 1;
      tick();
      chk0("t4.resume", 8, 1'b1, 1'b0);
      tick();
      chk0("t5.at9", 9, 1'b1, 1'b0);

      // T5: restart mid-run at 9
      rs0 = 1;
      tick();
      rs0 = 0;
      chk0("t5.rsRun", 0, 1'b1, 1'b0);
      tick();
      chk0("t5.hold2", 0, 1'b1, 1'b0);
      tick();
      chk0("t5.one", 1, 1'b1, 1'b0);
      for (int k = 2; k <= 6; k++) tick();
      chk0("t6.at6", 6, 1'b1, 1'b0);

      // T6: asynchronous reset between edges
      rstA = 1;
      #1;
      chk0("t6.async", 0, 1'b1, 1'b0);
      rstA = 0;
      tick();
      chk0("t6.hold", 0, 1'b1, 1'b0);
      tick();
      chk0("t6.one", 1, 1'b1, 1'b0);

      // T2: STEP=3, END=10, no hold
      en1 = 1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("t2.addr", 32'(a1), 32'(exp1A[k]));
         check("t2.fin", 32'(f1), 0);
      end
      tick();
      check("t2.doneAddr", 32'(a1), 9);
      check("t2.doneFin", 32'(f1), 1);
      check("t2.doneValid", 32'(v1), 0);
      tick();
      check("t2.absorb", 32'(a1), 9);

      // T3: wrapping sweep 2..5
      en2 = 1;
      for (int k = 0; k < 6; k++) begin
         tick();
         check("t3.addr", 32'(a2), 32'(exp2A[k]));
         check("t3.wrap", 32'(w2), 32'(exp2W[k]));
         check("t3.fin", 32'(f2), 0);
         check("t3.valid", 32'(v2), 1);
      end

      // T6: 8-bit full sweep, no false wrap at 255
      en3 = 1;
      tick();
      check("t6w.hold", 32'(a3), 0);
      for (int k = 1; k <= 255; k++) begin
         tick();
         check("t6w.addr", 32'(a3), 32'(k));
      end
      check("t6w.finEarly", 32'(f3), 0);
      tick();
      check("t6w.doneAddr", 32'(a3), 255);
      check("t6w.doneFin", 32'(f3), 1);
      check("t6w.doneValid", 32'(v3), 0);
      check("t6w.noWrap", 32'(w3), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               nCompared, nMismatched);
      $finish;
   end

endmodule
